// File: rtl/fwft_small_fifo_if.sv
// Purpose : handshake/data bundle between a producer/consumer and fwft_small_fifo.
// Latency : n/a (wires only).
// Backpressure: producer watches full/nearly_full/prog_full; consumer watches empty.
// Ports   : din/wr_en (write side), rd_en/dout (read side), full/nearly_full/prog_full/empty flags.
interface fwft_small_fifo_if #(
  parameter int WIDTH = 72
) ();
  logic [WIDTH-1:0] din;
  logic             wr_en;
  logic             rd_en;
  logic [WIDTH-1:0] dout;
  logic             full;
  logic             nearly_full;
  logic             prog_full;
  logic             empty;

  // Master: the user of the FIFO (drives writes and pops).
  modport master (
    output din, wr_en, rd_en,
    input  dout, full, nearly_full, prog_full, empty
  );

  // Slave: the FIFO itself.
  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, nearly_full, prog_full, empty
  );
endinterface

// File: rtl/fwft_small_fifo.sv
// Purpose : small synchronous first-word-fall-through FIFO for stream beats.
// Latency : word written at edge N is on dout (empty=0) right after edge N; pops take effect at the edge.
// Backpressure: writes while full are dropped; reads while empty are ignored; flags come from count only.
// Ports   : clk, reset (sync, active-high); fifo_if.slave carries din/wr_en/rd_en/dout and
//           full/nearly_full/prog_full/empty.
module fwft_small_fifo #(
  parameter int WIDTH               = 72,
  parameter int MAX_DEPTH_BITS      = 3,
  parameter int PROG_FULL_THRESHOLD = 2**MAX_DEPTH_BITS - 1
) (
  input  logic              clk,
  input  logic              reset,
  fwft_small_fifo_if.slave  fifo_if
);

  localparam int MAX_DEPTH = 2**MAX_DEPTH_BITS;
  localparam int CNT_W     = MAX_DEPTH_BITS + 1;
  localparam int PTR_W     = MAX_DEPTH_BITS;

  localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(MAX_DEPTH);
  localparam logic [CNT_W-1:0] CNT_NFULL = CNT_W'(MAX_DEPTH - 1);
  localparam logic [CNT_W-1:0] CNT_PFULL = CNT_W'(PROG_FULL_THRESHOLD);

  // Storage is intentionally not reset; dout is meaningless while empty.
  logic [WIDTH-1:0] mem_q [MAX_DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q,  count_d;

  logic full_w;
  logic empty_w;
  logic wr_accept;
  logic rd_accept;

  // Flags depend only on the registered count, so they never glitch on wr_en/rd_en.
  always_comb begin
    full_w  = (count_q == CNT_FULL);
    empty_w = (count_q == '0);
  end

  // Accept decisions use this cycle's flags: a pop does not make room for a
  // same-cycle write when full, and a write does not feed a same-cycle pop when empty.
  always_comb begin
    wr_accept = fifo_if.wr_en && !full_w;
    rd_accept = fifo_if.rd_en && !empty_w;
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_accept) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end
    if (rd_accept) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    case ({wr_accept, rd_accept})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_accept && !reset) begin
      mem_q[wr_ptr_q] <= fifo_if.din;
    end
  end

  // Fall-through: head entry is driven straight from the array.
  always_comb begin
    fifo_if.dout        = mem_q[rd_ptr_q];
    fifo_if.full        = full_w;
    fifo_if.empty       = empty_w;
    fifo_if.nearly_full = (count_q >= CNT_NFULL);
    fifo_if.prog_full   = (count_q >= CNT_PFULL);
  end

endmodule

// File: tb/tb_fwft_small_fifo.sv
// Purpose : self-checking bench for fwft_small_fifo (WIDTH=8, depth 8).
// Latency : checks every output half a cycle after each rising edge.
// Backpressure: covers full-drop, empty-read, simultaneous read/write and reset flush.
module tb_fwft_small_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;

  fwft_small_fifo_if #(.WIDTH(W)) intf ();

  fwft_small_fifo #(
    .WIDTH(W),
    .MAX_DEPTH_BITS(3),
    .PROG_FULL_THRESHOLD(7)
  ) dut (
    .clk(clk),
    .reset(reset),
    .fifo_if(intf.slave)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;

  // Reference model: a plain queue with capacity DEPTH.
  logic [W-1:0] model_q [$];

  typedef struct {
    logic         rst;
    logic         wr;
    logic         rd;
    logic [W-1:0] din;
    logic         e_empty;
    logic         e_full;
    logic         e_nfull;
    logic         e_pfull;
    logic         chk_dout;
    logic [W-1:0] e_dout;
  } vec_t;

  vec_t vecs [$];

  task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Drive one cycle, advance the model past the edge, stop at the falling edge.
  task automatic step(input logic r, input logic w, input logic rd, input logic [W-1:0] d);
    bit wa;
    bit ra;
    reset      = r;
    intf.wr_en = w;
    intf.rd_en = rd;
    intf.din   = d;
    @(posedge clk);
    if (r) begin
      model_q.delete();
    end else begin
      wa = w  && (model_q.size() < DEPTH);
      ra = rd && (model_q.size() > 0);
      if (ra) void'(model_q.pop_front());
      if (wa) model_q.push_back(d);
    end
    @(negedge clk);
  endtask

  task automatic chk_model(input string tag);
    int n;
    n = model_q.size();
    chk({tag, "_empty"}, W'(intf.empty),       W'(n == 0));
    chk({tag, "_full"},  W'(intf.full),        W'(n == DEPTH));
    chk({tag, "_nfull"}, W'(intf.nearly_full), W'(n >= DEPTH - 1));
    chk({tag, "_pfull"}, W'(intf.prog_full),   W'(n >= 7));
    if (n > 0) chk({tag, "_dout"}, intf.dout, model_q[0]);
  endtask

  task automatic add(input logic r, input logic w, input logic rd, input logic [W-1:0] d,
                     input logic e, input logic f, input logic nf, input logic pf,
                     input logic cd, input logic [W-1:0] ed);
    vec_t v;
    v.rst = r; v.wr = w; v.rd = rd; v.din = d;
    v.e_empty = e; v.e_full = f; v.e_nfull = nf; v.e_pfull = pf;
    v.chk_dout = cd; v.e_dout = ed;
    vecs.push_back(v);
  endtask

  initial begin
    reset      = 1'b1;
    intf.wr_en = 1'b0;
    intf.rd_en = 1'b0;
    intf.din   = '0;

    // ---------------- directed vector table ----------------
    add(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    add(1, 0, 0, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    add(0, 1, 0, 8'hA5, 0, 0, 0, 0, 1, 8'hA5);
    add(0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    for (int k = 1; k <= 8; k++)
      add(0, 1, 0, W'(k), 0, k == 8, k >= 7, k >= 7, 1, 8'h01);
    add(0, 1, 0, 8'hFF, 0, 1, 1, 1, 1, 8'h01);           // dropped while full
    for (int j = 1; j <= 8; j++)
      add(0, 0, 1, 8'h00, j == 8, 0, (8 - j) >= 7, (8 - j) >= 7, j < 8, W'(j + 1));
    add(0, 1, 1, 8'h3C, 0, 0, 0, 0, 1, 8'h3C);           // empty: write wins, read ignored
    add(0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00);
    add(0, 0, 1, 8'h00, 1, 0, 0, 0, 0, 8'h00);           // read on empty: no change

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].wr, vecs[i].rd, vecs[i].din);
      chk($sformatf("v%0d_empty", i), W'(intf.empty),       W'(vecs[i].e_empty));
      chk($sformatf("v%0d_full", i),  W'(intf.full),        W'(vecs[i].e_full));
      chk($sformatf("v%0d_nfull", i), W'(intf.nearly_full), W'(vecs[i].e_nfull));
      chk($sformatf("v%0d_pfull", i), W'(intf.prog_full),   W'(vecs[i].e_pfull));
      if (vecs[i].chk_dout) chk($sformatf("v%0d_dout", i), intf.dout, vecs[i].e_dout);
    end

    // ---------------- steady state across pointer wrap ----------------
    for (int i = 0; i < 4; i++) begin
      step(0, 1, 0, 8'(8'h40 + i));
      chk_model("fill4");
    end
    for (int i = 0; i < 20; i++) begin
      chk("wrap_head", intf.dout, 8'(8'h40 + i));
      step(0, 1, 1, 8'(8'h44 + i));
      chk("wrap_empty", W'(intf.empty),       8'h00);
      chk("wrap_full",  W'(intf.full),        8'h00);
      chk("wrap_nfull", W'(intf.nearly_full), 8'h00);
      chk("wrap_pfull", W'(intf.prog_full),   8'h00);
    end
    for (int i = 0; i < 4; i++) begin
      chk("wrap_drain", intf.dout, 8'(8'h54 + i));
      step(0, 0, 1, 8'h00);
    end
    chk("wrap_drained", W'(intf.empty), 8'h01);

    // ---------------- reset with 5 entries stored ----------------
    for (int i = 0; i < 5; i++) step(0, 1, 0, 8'(8'h70 + i));
    chk("pre_rst_head", intf.dout, 8'h70);
    step(1, 0, 0, 8'h00);
    chk("rst_empty", W'(intf.empty),       8'h01);
    chk("rst_full",  W'(intf.full),        8'h00);
    chk("rst_nfull", W'(intf.nearly_full), 8'h00);
    chk("rst_pfull", W'(intf.prog_full),   8'h00);
    step(0, 1, 0, 8'h11);
    chk("post_rst_empty", W'(intf.empty), 8'h00);
    chk("post_rst_dout",  intf.dout,      8'h11);
    step(0, 0, 1, 8'h00);
    chk("post_rst_pop", W'(intf.empty), 8'h01);

    // ---------------- randomized against the queue model ----------------
    for (int i = 0; i < 1500; i++) begin
      int wr_pct;
      wr_pct = ((i / 150) % 2 == 0) ? 75 : 30;   // alternate filling and draining bias
      step($urandom_range(0, 199) == 0,
           $urandom_range(0, 99) < wr_pct,
           $urandom_range(0, 99) < (100 - wr_pct),
           W'($urandom));
      chk_model("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
